add_pipe: RTL and testbench



---
 rtl/add_pipe.sv | 196 +++++++++++++++++++
 tb/tb_add_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : add_pipe
// Brief    : Pipelined adder/subtractor, carry chain split into STAGES chunks,
//            valid/ready flow control. Define ADD_PIPE_SAT_EN for signed clamp.
// Revision : 1.0 - initial release
// ============================================================================
module add_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int c_div   = (STAGES < 1) ? 1 : STAGES;
    localparam int c_chunk = WIDTH / c_div;

    if ((STAGES < 1) || ((WIDTH % c_div) != 0)) begin : g_param_check
        $error("add_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d) and STAGES >= 1",
               WIDTH, STAGES);
    end

    logic              w_en;
    logic              w_accept;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_cin_eff;
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_ld;
    logic [WIDTH-1:0]  w_opa;
    logic [WIDTH-1:0]  w_opb;
    logic [STAGES-1:0] w_cin_stage;
    logic [STAGES-1:0] w_carry;
    logic [WIDTH-1:0]  w_sum_raw;
    logic              w_msb_sum;
    logic              w_top_cout;
    logic              w_nxt_ovf;
    logic              r_ovf;

    assign w_en      = !r_valid[STAGES-1] || out_ready;
    assign in_ready  = w_en;
    assign w_accept  = in_valid && w_en;
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | cin;
    assign out_valid = r_valid[STAGES-1];
    assign cout      = w_carry[STAGES-1];
    assign ovf       = r_ovf;

    // Position p of the pipe loads only when a live beat enters it, so data
    // registers keep their cleared value after reset until real traffic arrives.
    always_comb begin
        w_vin    = r_valid << 1;
        w_vin[0] = w_accept;
    end
    assign w_ld = w_vin & {STAGES{w_en}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_en) begin
            r_valid <= w_vin;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        localparam int c_lsb   = k * c_chunk;
        localparam int c_depth = STAGES - 1 - k;

        logic [c_chunk:0]   w_add;
        logic [c_chunk-1:0] r_s;
        logic               r_c;

        if (k == 0) begin : g_head
            assign w_opa[c_lsb +: c_chunk] = a[c_lsb +: c_chunk];
            assign w_opb[c_lsb +: c_chunk] = w_b_eff[c_lsb +: c_chunk];
            assign w_cin_stage[k]          = w_cin_eff;
        end else begin : g_skew
            logic [c_chunk-1:0] r_ska [k];
            logic [c_chunk-1:0] r_skb [k];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < k; i++) begin
                        r_ska[i] <= '0;
                        r_skb[i] <= '0;
                    end
                end else begin
                    if (w_ld[0]) begin
                        r_ska[0] <= a[c_lsb +: c_chunk];
                        r_skb[0] <= w_b_eff[c_lsb +: c_chunk];
                    end
                    for (int i = 1; i < k; i++) begin
                        if (w_ld[i]) begin
                            r_ska[i] <= r_ska[i-1];
                            r_skb[i] <= r_skb[i-1];
                        end
                    end
                end
            end

            assign w_opa[c_lsb +: c_chunk] = r_ska[k-1];
            assign w_opb[c_lsb +: c_chunk] = r_skb[k-1];
            assign w_cin_stage[k]          = w_carry[k-1];
        end

        assign w_add = {1'b0, w_opa[c_lsb +: c_chunk]}
                     + {1'b0, w_opb[c_lsb +: c_chunk]}
                     + {{c_chunk{1'b0}}, w_cin_stage[k]};

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_s <= '0;
                r_c <= 1'b0;
            end else if (w_ld[k]) begin
                r_s <= w_add[c_chunk-1:0];
                r_c <= w_add[c_chunk];
            end
        end

        assign w_carry[k] = r_c;

        if (k == STAGES - 1) begin : g_tail
            assign w_msb_sum  = w_add[c_chunk-1];
            assign w_top_cout = w_add[c_chunk];
        end

        if (c_depth == 0) begin : g_direct
            assign w_sum_raw[c_lsb +: c_chunk] = r_s;
        end else begin : g_deskew
            logic [c_chunk-1:0] r_dsk [c_depth];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int j = 0; j < c_depth; j++) begin
                        r_dsk[j] <= '0;
                    end
                end else begin
                    if (w_ld[k+1]) begin
                        r_dsk[0] <= r_s;
                    end
                    for (int j = 1; j < c_depth; j++) begin
                        if (w_ld[k+1+j]) begin
                            r_dsk[j] <= r_dsk[j-1];
                        end
                    end
                end
            end

            assign w_sum_raw[c_lsb +: c_chunk] = r_dsk[c_depth-1];
        end
    end

    // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
    assign w_nxt_ovf = w_opa[WIDTH-1] ^ w_opb[WIDTH-1] ^ w_msb_sum ^ w_top_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ld[STAGES-1]) begin
            r_ovf <= w_nxt_ovf;
        end
    end

`ifdef ADD_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};

    logic r_neg;

    // On overflow both effective operands share a sign; A's MSB carries it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_neg <= 1'b0;
        end else if (w_ld[STAGES-1]) begin
            r_neg <= w_opa[WIDTH-1];
        end
    end

    assign sum = r_ovf ? (r_neg ? c_sat_min : c_sat_max) : w_sum_raw;
`else
    assign sum = w_sum_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_pipe
// Brief    : Scoreboard bench for add_pipe (WIDTH=16, STAGES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_pipe;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

`ifdef ADD_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] EXP_NEG_OVF = 16'h8000;
    localparam logic [WIDTH-1:0] EXP_POS_OVF = 16'h7FFF;
`else
    localparam logic [WIDTH-1:0] EXP_NEG_OVF = 16'h0FFF;
    localparam logic [WIDTH-1:0] EXP_POS_OVF = 16'h8000;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    exp_t             sb_q [$];
    exp_t             mon_exp;
    int               checks     = 0;
    int               errors     = 0;
    int               n_out      = 0;
    int               lat        = 0;
    bit               rand_ready = 1'b0;
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs;

    add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands as written.
    function automatic exp_t model(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                                   input logic fc, input logic fs);
        exp_t        e;
        int unsigned ua  = 32'(fa);
        int unsigned ub  = 32'(fb);
        int          sa  = int'($signed(fa));
        int          sbv = int'($signed(fb));
        int          lim = 2 ** (WIDTH - 1);
        int          sres;
        if (fs) begin
            sres   = sa - sbv;
            e.cout = (ua >= ub);
            e.sum  = WIDTH'(ua - ub);
        end else begin
            sres   = sa + sbv + 32'(fc);
            e.cout = ((ua + ub + 32'(fc)) >= (32'd1 << WIDTH));
            e.sum  = WIDTH'(ua + ub + 32'(fc));
        end
        e.ovf = (sres >= lim) || (sres < -lim);
`ifdef ADD_PIPE_SAT_EN
        if (e.ovf) e.sum = (sres > 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a result is consumed at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got sum %0h expected no beat", sum);
            end else begin
                mon_exp = sb_q.pop_front();
                check("sum",  32'(sum),  32'(mon_exp.sum));
                check("cout", 32'(cout), 32'(mon_exp.cout));
                check("ovf",  32'(ovf),  32'(mon_exp.ovf));
                n_out++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input logic ts, input exp_t e);
        int waits = 0;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready 0 expected 1");
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (sb_q.size() != 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bp_test();
        logic [WIDTH-1:0] hs;
        logic             hc, ho;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(WIDTH'(i), WIDTH'(i * 16'h1111), 1'b0, 1'b0,
                         model(WIDTH'(i), WIDTH'(i * 16'h1111), 1'b0, 1'b0));
                end
            end
            begin
                int base  = n_out;
                int guard = 0;
                while (n_out < base + 2 && guard < 200) begin
                    @(posedge clk);
                    guard++;
                end
                check("bp_second_result_seen", 32'(n_out >= base + 2), 32'd1);
                #1 out_ready = 1'b0;
                @(negedge clk);
                hs = sum; hc = cout; ho = ovf;
                check("bp_in_ready_stall0", 32'(in_ready), 32'd0);
                check("bp_out_valid_stall0", 32'(out_valid), 32'd1);
                for (int s = 1; s < 3; s++) begin
                    @(negedge clk);
                    check("bp_in_ready_stall", 32'(in_ready), 32'd0);
                    check("bp_sum_stable",  32'(sum),  32'(hs));
                    check("bp_cout_stable", 32'(cout), 32'(hc));
                    check("bp_ovf_stable",  32'(ovf),  32'(ho));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(negedge clk);
                check("bp_in_ready_release", 32'(in_ready), 32'd1);
            end
        join
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum",       32'(sum),       32'd0);
        check("reset_cout",      32'(cout),      32'd0);
        check("reset_ovf",       32'(ovf),       32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(16'h1234, 16'h0101, 1'b0, 1'b0, '{sum: 16'h1335, cout: 1'b0, ovf: 1'b0});
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency", 32'(lat), 32'(STAGES));
        drain();

        send(16'h8FFF, 16'h8000, 1'b0, 1'b0, '{sum: EXP_NEG_OVF, cout: 1'b1, ovf: 1'b1});
        send(16'h0000, 16'hFFFF, 1'b1, 1'b0, '{sum: 16'h0000,    cout: 1'b1, ovf: 1'b0});
        send(16'h0001, 16'h0002, 1'b1, 1'b1, '{sum: 16'hFFFF,    cout: 1'b0, ovf: 1'b0});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{sum: EXP_POS_OVF, cout: 1'b0, ovf: 1'b1});
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;

        bp_test();

        for (int i = 1; i <= 3; i++) begin
            send(WIDTH'(16'h1111 * i), 16'h0F0F, 1'b0, 1'b0,
                 model(WIDTH'(16'h1111 * i), 16'h0F0F, 1'b0, 1'b0));
        end
        rst_n = 1'b0;
        a = 16'hFFFF;
        b = 16'h7FFF;
        sb_q.delete();
        @(negedge clk);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midreset_out_valid", 32'(out_valid), 32'd0);
            check("midreset_sum",       32'(sum),       32'd0);
            check("midreset_cout",      32'(cout),      32'd0);
            check("midreset_ovf",       32'(ovf),       32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h4000, 16'h4000, 1'b0, 1'b0, model(16'h4000, 16'h4000, 1'b0, 1'b0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
